// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: Moore decode of state (plus mem_ready) with a memory-wait timeout.
// Optional addi support is enabled by defining MC_ADDI_EN.
module mc_main_control #(
  parameter int unsigned MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXEC      = 4'd6,
    S_RTYPE_WB  = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_RESET     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef MC_ADDI_EN
  localparam logic ADDI_EN = 1'b1;
`else
  localparam logic ADDI_EN = 1'b0;
`endif

  localparam logic       TMO_EN    = (MEM_WAIT_MAX != 0);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       in_wait;
  logic       timeout;
  logic       unused_zero;

  assign unused_zero = zero;
  assign state       = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    state_d     = S_FETCH;

    in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // mem_ready has priority: a completing access never times out
    timeout = TMO_EN && in_wait && !mem_ready && (wait_cnt_q == WAIT_LAST);

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI: begin
            if (ADDI_EN) state_d = S_ADDI_EXEC;
            else         illegal_op = 1'b1;
          end
          default:      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = S_RTYPE_WB;
      end
      S_RTYPE_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EXEC: begin
        if (ADDI_EN) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = S_ADDI_WB;
        end
      end
      S_ADDI_WB: begin
        if (ADDI_EN) RegWrite = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      mem_timeout = 1'b1;
      state_d     = S_FETCH;
    end

    // explicit timeout clear matters in FETCH, where the retry keeps the same state
    if ((state_d != state_q) || mem_ready || timeout || !in_wait)
      wait_cnt_d = '0;
    else
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed vector table, async-reset check, and random run vs. a reference model.
module tb_mc_main_control;

  localparam int MAXW = 4;

  localparam logic [17:0] PCW      = 18'h1 << 17;
  localparam logic [17:0] PCWC     = 18'h1 << 16;
  localparam logic [17:0] IORD     = 18'h1 << 15;
  localparam logic [17:0] MRD      = 18'h1 << 14;
  localparam logic [17:0] MWR      = 18'h1 << 13;
  localparam logic [17:0] M2R      = 18'h1 << 12;
  localparam logic [17:0] IRW      = 18'h1 << 11;
  localparam logic [17:0] SRCA     = 18'h1 << 10;
  localparam logic [17:0] RW       = 18'h1 << 9;
  localparam logic [17:0] RDST     = 18'h1 << 8;
  localparam logic [17:0] PCS_OUT  = 18'h1 << 6;
  localparam logic [17:0] PCS_J    = 18'h2 << 6;
  localparam logic [17:0] SRCB_4   = 18'h1 << 4;
  localparam logic [17:0] SRCB_IMM = 18'h2 << 4;
  localparam logic [17:0] SRCB_SH  = 18'h3 << 4;
  localparam logic [17:0] OP_SUB   = 18'h1 << 2;
  localparam logic [17:0] OP_FN    = 18'h2 << 2;
  localparam logic [17:0] ILL      = 18'h2;
  localparam logic [17:0] TMO      = 18'h1;

  localparam logic [17:0] W_FETCH_RDY  = MRD | SRCB_4 | IRW | PCW;
  localparam logic [17:0] W_FETCH_WAIT = MRD | SRCB_4;
  localparam logic [17:0] W_DEC        = SRCB_SH;
  localparam logic [17:0] W_ADR        = SRCA | SRCB_IMM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       ALUSrcA, RegWrite, RegDst, illegal_op, mem_timeout;
  logic [1:0] PCSource, ALUSrcB, ALUop;
  logic [3:0] state;
  logic [17:0] dut_w;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] w;
  } vec_t;
  vec_t vecs[$];

  logic [17:0] base_w [16];
  int m_st, m_cnt;

  mc_main_control #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUop(ALUop), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  assign dut_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUop, illegal_op, mem_timeout};

  always #5 clk = ~clk;

  function automatic void add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                              input logic [17:0] w);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.w = w;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input logic [3:0] ast, input logic [17:0] aw,
                     input logic [3:0] est, input logic [17:0] ew);
    n_cmp++;
    if ({ast, aw} !== {est, ew}) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctrl=%05h, expected state=%0d ctrl=%05h", nm, ast, aw, est, ew);
    end
  endtask

  // Reference: per-state control word plus the handshake/dispatch/timeout rules.
  function automatic void model(input int st, input logic [5:0] op, input logic rdy, input int cnt,
                                output logic [17:0] w, output int nst, output int ncnt);
    bit waits, tmo, addi;
    addi  = 1'b0;
`ifdef MC_ADDI_EN
    addi  = 1'b1;
`endif
    waits = (st == 0) || (st == 3) || (st == 5);
    tmo   = waits && !rdy && (cnt == MAXW - 1);
    w     = base_w[st];
    nst   = 0;
    case (st)
      0: begin
        if (rdy) begin w |= IRW | PCW; nst = 1; end
      end
      1: begin
        if (op == 6'h00) nst = 6;
        else if (op == 6'h23 || op == 6'h2B) nst = 2;
        else if (op == 6'h04) nst = 8;
        else if (op == 6'h02) nst = 9;
        else if (op == 6'h08 && addi) nst = 10;
        else w |= ILL;
      end
      2: nst = (op == 6'h2B) ? 5 : 3;
      3: nst = rdy ? 4 : 3;
      5: nst = rdy ? 0 : 5;
      6: nst = 7;
      10: nst = addi ? 11 : 0;
      default: nst = 0;
    endcase
    if (tmo) begin w |= TMO; nst = 0; end
    ncnt = (waits && !rdy && !tmo && nst == st) ? cnt + 1 : 0;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    opcode = v.op;
    mem_ready = v.rdy;
    #1 cmp(nm, state, dut_w, v.st, v.w);
  endtask

  task automatic model_step(input string nm);
    logic [17:0] ew;
    int nst, ncnt;
    model(m_st, opcode, mem_ready, m_cnt, ew, nst, ncnt);
    cmp(nm, state, dut_w, 4'(m_st), ew);
    m_st = nst;
    m_cnt = ncnt;
  endtask

  initial begin
    foreach (base_w[i]) base_w[i] = '0;
    base_w[0] = W_FETCH_WAIT;
    base_w[1] = W_DEC;
    base_w[2] = W_ADR;
    base_w[3] = MRD | IORD;
    base_w[4] = M2R | RW;
    base_w[5] = MWR | IORD;
    base_w[6] = SRCA | OP_FN;
    base_w[7] = RDST | RW;
    base_w[8] = SRCA | OP_SUB | PCWC | PCS_OUT;
    base_w[9] = PCW | PCS_J;
`ifdef MC_ADDI_EN
    base_w[10] = SRCA | SRCB_IMM;
    base_w[11] = RW;
`endif

    // R-type
    add(6'h00, 1, 0, W_FETCH_RDY); add(6'h00, 1, 1, W_DEC);
    add(6'h00, 1, 6, SRCA | OP_FN); add(6'h00, 1, 7, RDST | RW);
    // lw with three wait cycles, ready on the 4th (counter at MAXW-1: ready wins)
    add(6'h23, 1, 0, W_FETCH_RDY); add(6'h23, 1, 1, W_DEC); add(6'h23, 1, 2, W_ADR);
    add(6'h23, 0, 3, MRD | IORD); add(6'h23, 0, 3, MRD | IORD); add(6'h23, 0, 3, MRD | IORD);
    add(6'h23, 1, 3, MRD | IORD); add(6'h23, 1, 4, M2R | RW);
    // beq, j
    add(6'h04, 1, 0, W_FETCH_RDY); add(6'h04, 1, 1, W_DEC);
    add(6'h04, 1, 8, SRCA | OP_SUB | PCWC | PCS_OUT);
    add(6'h02, 1, 0, W_FETCH_RDY); add(6'h02, 1, 1, W_DEC); add(6'h02, 1, 9, PCW | PCS_J);
    // illegal opcode
    add(6'h3F, 1, 0, W_FETCH_RDY); add(6'h3F, 1, 1, W_DEC | ILL); add(6'h3F, 0, 0, W_FETCH_WAIT);
    // sw with memory stuck: timeout on 4th MEMWR cycle, then a FETCH timeout
    add(6'h2B, 1, 0, W_FETCH_RDY); add(6'h2B, 1, 1, W_DEC); add(6'h2B, 1, 2, W_ADR);
    add(6'h2B, 0, 5, MWR | IORD); add(6'h2B, 0, 5, MWR | IORD); add(6'h2B, 0, 5, MWR | IORD);
    add(6'h2B, 0, 5, MWR | IORD | TMO);
    add(6'h2B, 0, 0, W_FETCH_WAIT); add(6'h2B, 0, 0, W_FETCH_WAIT); add(6'h2B, 0, 0, W_FETCH_WAIT);
    add(6'h2B, 0, 0, W_FETCH_WAIT | TMO);
    add(6'h00, 0, 0, W_FETCH_WAIT); add(6'h00, 0, 0, W_FETCH_WAIT); add(6'h00, 0, 0, W_FETCH_WAIT);
    add(6'h00, 1, 0, W_FETCH_RDY); add(6'h08, 1, 1, W_DEC
`ifndef MC_ADDI_EN
        | ILL
`endif
    );
`ifdef MC_ADDI_EN
    add(6'h08, 1, 10, SRCA | SRCB_IMM); add(6'h08, 1, 11, RW);
`endif
    add(6'h2B, 1, 0, W_FETCH_RDY); add(6'h2B, 1, 1, W_DEC); add(6'h2B, 1, 2, W_ADR);
    add(6'h2B, 0, 5, MWR | IORD);

    #1 rst_n = 1'b0;
    #1 cmp("reset_state", state, dut_w, 4'd15, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 cmp("reset_hold", state, dut_w, 4'd15, '0);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // async reset in the middle of MEMWR, no clock edge
    #1 rst_n = 1'b0;
    #1 cmp("async_reset", state, dut_w, 4'd15, '0);

    // random run against the reference model
    @(negedge clk);
    rst_n = 1'b1;
    m_st = 15;
    m_cnt = 0;
    mem_ready = 1'b1;
    #1 model_step("rand_reset");
    for (int unsigned i = 0; i < 3000; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 7))
        0: opcode = 6'h00;
        1: opcode = 6'h23;
        2: opcode = 6'h2B;
        3: opcode = 6'h04;
        4: opcode = 6'h02;
        5: opcode = 6'h08;
        6: opcode = 6'h3F;
        default: opcode = 6'($urandom);
      endcase
      mem_ready = ($urandom_range(0, 99) < 45);
      #1 model_step($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle MIPS main control FSM. Sits directly upstream of ALU_Control and drives its 2-bit ALUop.
- Also drives all datapath enables and muxes: PC, memory, IR, register file, and ALU source selects.
- Moore machine with a memory-ready handshake and a wait timeout; it sequences one instruction over 3–5+ cycles.

Parameters:
- MEM_WAIT_MAX, 255: maximum cycles to wait for mem_ready in a memory state; 0 disables the timeout; 8-bit counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  IR[31:26]; stable from the cycle after the IR write
- zero  input  1  ALU zero flag; used only by the datapath PC-enable logic and exposed here for the testbench
- mem_ready  input  1  memory has completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcB  output  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- ALUop  output  2  00 add, 01 sub, 10 use funct (fed to ALU_Control)
- illegal_op  output  1  one-cycle pulse for an unsupported opcode
- mem_timeout  output  1  one-cycle pulse when a memory wait expires
- state  output  4  current state, for debug

Behaviour:
- State register and wait counter are reset asynchronously on rst_n low.
  - State goes to RESET (4'd15); counter goes to 0.
- Every output is a combinational decode of state (plus mem_ready, as noted below). In RESET all outputs are 0.
- RESET always goes to FETCH on the next clock.
- Any control not listed for a state below is 0.
- State encodings and actions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
    - IRWrite=PCWrite=mem_ready.
    - If mem_ready, go to DECODE; otherwise stay.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUop=00 (precomputes the branch target).
    - Opcode dispatch: 000000 goes to EXEC; 100011 and 101011 go to MEMADR; 000100 goes to BRANCH; 000010 goes to JUMP.
    - Any other opcode goes to FETCH with illegal_op=1 during DECODE.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUop=00. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. If mem_ready, go to MEMWB; otherwise stay.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Then go to FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. If mem_ready, go to FETCH; otherwise stay.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUop=10. Then go to RTYPE_WB.
  - RTYPE_WB(7): RegDst=1, MemtoReg=0, RegWrite=1. Then go to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Then go to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Then go to FETCH.
  - Unused encodings go to FETCH, with all outputs 0.
- Wait counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
- Timeout (when MEM_WAIT_MAX≠0):
  - Fires when the counter equals MEM_WAIT_MAX-1 and mem_ready=0.
  - mem_timeout=1 for that cycle; the next state is FETCH and the counter clears.
  - In FETCH the timeout re-fetches: PCWrite stays 0, so the PC is unchanged.
- mem_ready and the timeout condition in the same cycle: mem_ready wins, and the normal transition is taken.
- Reset asserted mid-instruction: immediate return to RESET; write-enables drop asynchronously.
- opcode is ignored outside DECODE and MEMADR.

Optional Feature:
- Macro: MC_ADDI_EN.
- With the macro defined: opcode 001000 (addi) in DECODE goes to ADDI_EXEC(10), then ADDI_WB(11), then FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1.
- Without the macro: 001000 is illegal (illegal_op pulse, then FETCH), and encodings 10 and 11 behave as unused.

Test Plan:
- Reset, then release with mem_ready=1 and opcode=000000: state sequence is 15, 0, 1, 6, 7, 0. ALUop=10 in EXEC; RegWrite=1 and RegDst=1 only in state 7.
- lw (100011) with mem_ready low for 3 cycles in MEMRD: states 0, 1, 2, 3, 3, 3, 3, 4, 0. MemtoReg=1 and RegWrite=1 in state 4; IorD=1 throughout MEMRD.
- beq (000100): BRANCH asserts ALUop=01, PCWriteCond=1, PCSource=01 for exactly one cycle. j (000010): JUMP asserts PCWrite=1, PCSource=10.
- Opcode 111111: illegal_op pulses in DECODE, next state is FETCH, and no RegWrite, MemWrite or PCWrite is asserted after FETCH.
- MEM_WAIT_MAX=4 with sw and mem_ready held 0: mem_timeout pulses on the 4th MEMWR cycle, then FETCH; MemWrite=0 after the pulse.
- rst_n low mid-MEMWR: outputs go to 0 without a clock edge, and state=15. With MC_ADDI_EN, addi gives states 1, 10, 11, 0.
